// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, queue entry layout
// and the per-instruction PC step.
package fetch_pkg;
  localparam int FETCH_AW = 32;
  localparam int FETCH_IW = 32;
  localparam int PC_INC   = FETCH_IW / 8;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_IW-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, inst} entries; flush wins over push and pop.
import fetch_pkg::*;

module fetch_queue #(
  parameter  int QDEPTH = 2,
  localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CW     = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  fetch_entry_t    r_mem [QDEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_cnt;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= r_wr + PW'(1);
      if (pop)  r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) r_mem[r_wr] <= din;
  end

  assign count = r_cnt;
  assign full  = (r_cnt == CW'(QDEPTH));
  assign empty = (r_cnt == '0);
  assign dout  = empty ? '0 : r_mem[r_rd];
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, drives the ROM, queues {pc, inst} pairs for
// decode and traps misaligned redirect targets into a FAULT state.
import fetch_pkg::*;

module inst_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          INST_WIDTH   = 32,
  parameter int          QDEPTH       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rom_ce,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [INST_WIDTH-1:0] rom_inst,
  input  logic                  fetch_halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_pc
);
  localparam int SHIFT = $clog2(INST_WIDTH / 8);
  localparam int CW    = $clog2(QDEPTH) + 1;

  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_fault_pc;

  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] w_fpc_nxt;
  logic                  w_take;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_aligned;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  fetch_entry_t          w_din;
  fetch_entry_t          w_dout;

  assign w_aligned = (redirect_pc[SHIFT-1:0] == '0);
  assign w_valid   = !rst && (r_state == RUN) && !w_empty;
  assign w_pop     = w_valid && out_ready;
  // A full queue still accepts a fetch when decode drains the head this cycle.
  assign w_take    = !rst && (r_state == RUN) && !fetch_halt && !redirect_valid &&
                     (!w_full || w_pop);

  assign w_din.pc   = r_pc;
  assign w_din.inst = rom_inst;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_take),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fpc_nxt   = r_fault_pc;
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc;
      if (w_aligned) begin
        w_state_nxt = RUN;
      end else begin
        w_state_nxt = FAULT;
        w_fpc_nxt   = redirect_pc;
      end
    end else if (w_take) begin
      w_pc_nxt = r_pc + ADDR_WIDTH'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= ADDR_WIDTH'(RESET_VECTOR);
      r_fault_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_fault_pc <= w_fpc_nxt;
    end
  end

  assign rom_ce    = w_take;
  assign rom_addr  = r_pc;
  assign out_valid = w_valid;
  assign out_pc    = w_valid ? w_dout.pc   : '0;
  assign out_inst  = w_valid ? w_dout.inst : '0;
  assign fault     = !rst && (r_state == FAULT);
  assign fault_pc  = rst ? '0 : r_fault_pc;

  logic unused_ok;
  assign unused_ok = ^w_count;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios then random traffic, every
// cycle compared against a queue-based behavioural model.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        fetch_halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  bit          m_fault;

  inst_fetch_unit #(.RESET_VECTOR(32'h0), .ADDR_WIDTH(32), .INST_WIDTH(32), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .fetch_halt(fetch_halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign rom_inst = rom_f(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_inst.delete();
    m_pc    = 32'h0;
    m_fpc   = 32'h0;
    m_fault = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, compare just before the
  // rising edge, then advance the model with the same inputs.
  task automatic cyc(input bit r, input bit h, input bit rv, input logic [31:0] rp, input bit rdy);
    bit e_ov, e_take, e_pop;
    @(negedge clk);
    rst = r; fetch_halt = h; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
    #1;
    e_ov   = !r && !m_fault && (mq_pc.size() > 0);
    e_pop  = e_ov && rdy;
    e_take = !r && !m_fault && !h && !rv && (mq_pc.size() < 2 || e_pop);
    chk("rom_ce",    {31'b0, rom_ce},    {31'b0, e_take});
    chk("rom_addr",  rom_addr,           m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
    chk("out_pc",    out_pc,             e_ov ? mq_pc[0]   : 32'h0);
    chk("out_inst",  out_inst,           e_ov ? mq_inst[0] : 32'h0);
    chk("fault",     {31'b0, fault},     {31'b0, !r && m_fault});
    chk("fault_pc",  fault_pc,           r ? 32'h0 : m_fpc);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (e_pop) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (rv) begin
        mq_pc.delete();
        mq_inst.delete();
        m_pc = rp;
        if (rp[1:0] == 2'b00) m_fault = 1'b0;
        else begin
          m_fault = 1'b1;
          m_fpc   = rp;
        end
      end else if (e_take) begin
        mq_pc.push_back(m_pc);
        mq_inst.push_back(rom_f(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    logic [31:0] tgt;
    rst = 1'b1; fetch_halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    // Reset state visible while rst is held
    cyc(1, 0, 0, 0, 1);
    // Streaming from reset vector
    repeat (4) cyc(0, 0, 0, 0, 1);
    // Backpressure: two pushes then stall, then drain in order
    cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 1);
    // Redirect with a full queue
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);
    // Misaligned redirect then recovery
    cyc(0, 0, 1, 32'h42, 1);
    repeat (4) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h43, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h80, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    // Address wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    // Halt drains the queue
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);
    // Reset mid-stream
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tgt = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8;
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 3) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
